// File: rtl/battleship_nios2_qsys_0_ocimem_pkg.sv
// Shared types and JTAG command field positions for the OCI debug-memory controller.
// Every file that decodes jdo or walks the controller states imports this package.
package battleship_nios2_qsys_0_ocimem_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_LSB  = 10;
    localparam int RD_BIT    = 35;
    localparam int WDATA_LSB = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JRD   = 2'd1,
        JWR   = 2'd2,
        CPURD = 2'd3
    } state_t;

    // True when at least two of the three command pulses are high together.
    function automatic logic multi_pulse(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/battleship_nios2_qsys_0_ocimem_ram.sv
// Single-port 32-bit debug RAM with a one-cycle registered read.
// On a write, q returns the data being written (write-first).
module battleship_nios2_qsys_0_ocimem_ram
    import battleship_nios2_qsys_0_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W) - 1];

    // Array write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
            q           <= wdata;
        end else begin
            q <= mem_r[addr];
        end
    end

endmodule

// File: rtl/battleship_nios2_qsys_0_ocimem_ctrl.sv
// Debugger-side (JTAG) and CPU-side access controller for the on-chip debug RAM.
// JTAG commands always win arbitration; a losing CPU request is stalled and retried.
module battleship_nios2_qsys_0_ocimem_ctrl
    import battleship_nios2_qsys_0_ocimem_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest
);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              incr_r;

    logic [ADDR_W-1:0] jtag_addr_s;
    logic              jtag_rd_s;
    logic [DATA_W-1:0] jtag_wdata_s;
    logic              any_take_s;
    logic              multi_take_s;
    logic              cpu_done_s;
    logic              jdo_unused_s;

    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_q_s;

    assign jtag_addr_s  = jdo[ADDR_LSB +: ADDR_W];
    assign jtag_rd_s    = jdo[RD_BIT];
    assign jtag_wdata_s = jdo[WDATA_LSB +: DATA_W];
    assign jdo_unused_s = ^{jdo[37:36], jdo[2:0]};

    assign any_take_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_take_s = multi_pulse(take_action_ocimem_a, take_action_ocimem_b,
                                      take_no_action_ocimem_a);

    // CPU transfer completes on an uncontested write in IDLE or in the read data cycle.
    assign cpu_done_s = ((state_r == IDLE) & ~any_take_s & cpu_write) |
                        ((state_r == CPURD) & cpu_read);
    assign cpu_waitrequest = reset | ((cpu_read | cpu_write) & ~cpu_done_s);

    // RAM port steering; writes are suppressed while reset is high.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = addr_r;
        ram_wdata_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    ram_addr_s = jtag_addr_s;
                end else if (take_action_ocimem_b | take_no_action_ocimem_a) begin
                    ram_addr_s = addr_r;
                end else if (cpu_write) begin
                    ram_we_s    = ~reset;
                    ram_addr_s  = cpu_address;
                    ram_wdata_s = cpu_writedata;
                end else if (cpu_read) begin
                    ram_addr_s = cpu_address;
                end else begin
                    ram_addr_s = addr_r;
                end
            end
            JWR: begin
                ram_we_s = ~reset;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    battleship_nios2_qsys_0_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .q     (ram_q_s)
    );

    // Controller FSM with registered status and read-data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            addr_r        <= ADDR_W'(RESET_ADDR);
            wdata_r       <= '0;
            incr_r        <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            cpu_readdata  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        addr_r        <= jtag_addr_s;
                        monitor_error <= multi_take_s;
                        if (jtag_rd_s) begin
                            monitor_ready <= 1'b0;
                            incr_r        <= 1'b0;
                            state_r       <= JRD;
                        end else begin
                            monitor_ready <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        wdata_r       <= jtag_wdata_s;
                        monitor_ready <= 1'b0;
                        monitor_error <= monitor_error | multi_take_s;
                        state_r       <= JWR;
                    end else if (take_no_action_ocimem_a) begin
                        monitor_ready <= 1'b0;
                        incr_r        <= 1'b1;
                        state_r       <= JRD;
                    end else if (cpu_read & ~cpu_write) begin
                        state_r <= CPURD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                JRD: begin
                    MonDReg       <= ram_q_s;
                    monitor_ready <= 1'b1;
                    monitor_error <= monitor_error | any_take_s;
                    if (incr_r) begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end else begin
                        addr_r <= addr_r;
                    end
                    state_r <= IDLE;
                end
                JWR: begin
                    addr_r        <= addr_r + ADDR_W'(1);
                    monitor_ready <= 1'b1;
                    monitor_error <= monitor_error | any_take_s;
                    state_r       <= IDLE;
                end
                CPURD: begin
                    cpu_readdata  <= ram_q_s;
                    monitor_error <= monitor_error | any_take_s;
                    state_r       <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battleship_nios2_qsys_0_ocimem_ctrl.sv
// Directed self-checking bench for the OCI debug-memory controller.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_battleship_nios2_qsys_0_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;

    int checks   = 0;
    int failures = 0;

    battleship_nios2_qsys_0_ocimem_ctrl #(.ADDR_W(8), .RESET_ADDR(0)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] cmd_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j        = 38'd0;
        j[17:10] = a;
        j[35]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] cmd_b(input logic [31:0] d);
        logic [37:0] j;
        j       = 38'd0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic pulse_a(input logic [7:0] a);
        @(negedge clk);
        jdo = cmd_a(a, 1'b0);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        check_value("a_ready", {31'd0, monitor_ready}, 32'd1);
        check_value("a_error", {31'd0, monitor_error}, 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_b(input logic [31:0] d);
        @(negedge clk);
        jdo = cmd_b(d);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        check_value("b_busy", {31'd0, monitor_ready}, 32'd0);
        @(negedge clk);
        check_value("b_ready", {31'd0, monitor_ready}, 32'd1);
    endtask

    task automatic jtag_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        jdo = cmd_a(a, 1'b1);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        check_value({tag, "_busy"}, {31'd0, monitor_ready}, 32'd0);
        @(negedge clk);
        check_value(tag, MonDReg, exp);
        check_value({tag, "_ready"}, {31'd0, monitor_ready}, 32'd1);
        check_value({tag, "_err"}, {31'd0, monitor_error}, 32'd0);
    endtask

    task automatic pulse_n(input string tag, input logic [31:0] exp);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        check_value(tag, MonDReg, exp);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_address   = a;
        cpu_writedata = d;
        cpu_write     = 1'b1;
        #1;
        check_value("cpu_wr_wait", {31'd0, cpu_waitrequest}, 32'd0);
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input string tag, input logic [7:0] a, input logic with_b,
                          input logic [31:0] bdata, input logic [31:0] exp,
                          input int min_wait, input int max_wait);
        int   waits;
        logic done;
        waits = 0;
        done  = 1'b0;
        @(negedge clk);
        cpu_address = a;
        cpu_read    = 1'b1;
        if (with_b) begin
            jdo = cmd_b(bdata);
            take_action_ocimem_b = 1'b1;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (cpu_waitrequest) begin
                waits++;
                @(negedge clk);
                take_action_ocimem_b = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        check_value({tag, "_done"}, {31'd0, done}, 32'd1);
        check_value({tag, "_waits_ok"}, {31'd0, (waits >= min_wait) && (waits <= max_wait)}, 32'd1);
        @(negedge clk);
        cpu_read = 1'b0;
        check_value(tag, cpu_readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        jdo = 38'd0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address = 8'd0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = 32'd0;

        repeat (3) @(negedge clk);
        check_value("rst_mondreg", MonDReg, 32'd0);
        check_value("rst_ready", {31'd0, monitor_ready}, 32'd0);
        check_value("rst_error", {31'd0, monitor_error}, 32'd0);
        check_value("rst_readdata", cpu_readdata, 32'd0);
        check_value("rst_wait", {31'd0, cpu_waitrequest}, 32'd1);
        reset = 1'b0;

        // Address load without read.
        pulse_a(8'h10);
        check_value("a10_mondreg", MonDReg, 32'd0);

        // Marker words for post-increment and wrap checks.
        cpu_wr(8'h13, 32'h1313_1313);
        cpu_wr(8'h00, 32'hA5A5_A5A5);

        pulse_b(32'hDEAD_BEEF);
        pulse_b(32'h1234_5678);
        pulse_b(32'hCAFE_F00D);
        pulse_n("addr_after_writes", 32'h1313_1313);

        // Read with load (no increment) then two sequential reads.
        jtag_read("rd10", 8'h10, 32'hDEAD_BEEF);
        pulse_n("seq0", 32'hDEAD_BEEF);
        pulse_n("seq1", 32'h1234_5678);
        pulse_n("seq2", 32'hCAFE_F00D);

        // Address wrap at the top of the RAM.
        pulse_a(8'hFF);
        pulse_b(32'h0000_0001);
        pulse_n("wrap_addr0", 32'hA5A5_A5A5);
        jtag_read("rdFF", 8'hFF, 32'h0000_0001);

        // Plain CPU read, then a CPU read losing to a JTAG write.
        cpu_rd("cpu_rd12", 8'h12, 1'b0, 32'd0, 32'hCAFE_F00D, 1, 1);
        pulse_a(8'h20);
        cpu_rd("cpu_rd11_contend", 8'h11, 1'b1, 32'h0000_0055, 32'h1234_5678, 2, 4);
        jtag_read("rd20", 8'h20, 32'h0000_0055);

        // Simultaneous pulses: ocimem_a executes, collision flagged.
        @(negedge clk);
        jdo = cmd_a(8'h10, 1'b0);
        take_action_ocimem_a = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        check_value("multi_error", {31'd0, monitor_error}, 32'd1);
        pulse_n("multi_addr", 32'hDEAD_BEEF);
        pulse_a(8'h20);

        // ocimem_b while busy with a sequential read is dropped.
        cpu_wr(8'h21, 32'h0BAD_F00D);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        jdo = cmd_b(32'h0000_0077);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        check_value("busy_mondreg", MonDReg, 32'h0000_0055);
        check_value("busy_error", {31'd0, monitor_error}, 32'd1);
        @(negedge clk);
        check_value("busy_error_sticky", {31'd0, monitor_error}, 32'd1);
        jtag_read("rd21_dropped", 8'h21, 32'h0BAD_F00D);

        // Reset while the JTAG write is pending.
        cpu_wr(8'h30, 32'h1111_2222);
        pulse_a(8'h30);
        @(negedge clk);
        jdo = cmd_b(32'h9999_9999);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        reset = 1'b1;
        #1;
        check_value("midrst_wait", {31'd0, cpu_waitrequest}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        check_value("midrst_ready", {31'd0, monitor_ready}, 32'd0);
        check_value("midrst_mondreg", MonDReg, 32'd0);
        jtag_read("rd30_after_rst", 8'h30, 32'h1111_2222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
